// File: rtl/component_rank_sweep.sv
// Sweeps every node through a query/response port, ranks the TOP_N qualifying
// component roots by size, then forms the product of the ranked sizes.
module component_rank_sweep #(
  parameter int unsigned NODE_COUNT    = 2000,
  parameter int unsigned INDEX_WIDTH   = $clog2(NODE_COUNT),
  parameter int unsigned SIZE_WIDTH    = INDEX_WIDTH + 1,
  parameter int unsigned TOP_N         = 3,
  parameter int unsigned MODE          = 0,
  parameter int unsigned PRODUCT_WIDTH = SIZE_WIDTH * TOP_N
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           q_valid,
  input  logic                           q_ready,
  output logic [INDEX_WIDTH-1:0]         q_index,
  input  logic                           r_valid,
  input  logic                           r_is_root,
  input  logic [SIZE_WIDTH-1:0]          r_size,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TOP_N*SIZE_WIDTH-1:0]    top_sizes,
  output logic [TOP_N*INDEX_WIDTH-1:0]   top_roots,
  output logic [INDEX_WIDTH:0]           roots_found,
  output logic [PRODUCT_WIDTH-1:0]       top_product,
  output logic                           overflow
);

  localparam int unsigned CNT_WIDTH  = INDEX_WIDTH + 1;
  localparam int unsigned FILL_WIDTH = $clog2(TOP_N + 1);
  localparam int unsigned WIDE_WIDTH = 2 * PRODUCT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] NODE_MAX = CNT_WIDTH'(NODE_COUNT);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NODE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, PRODUCT, HOLD} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    q_cnt;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [SIZE_WIDTH-1:0]   size_q [TOP_N];
  logic [INDEX_WIDTH-1:0]  root_q [TOP_N];
  logic [PRODUCT_WIDTH-1:0] acc;
  logic [FILL_WIDTH-1:0]   prod_idx;

  logic                    qualify;
  logic [TOP_N:0]          better_ext;
  logic [SIZE_WIDTH-1:0]   size_ext [TOP_N+1];
  logic [INDEX_WIDTH-1:0]  root_ext [TOP_N+1];
  logic [SIZE_WIDTH-1:0]   size_n [TOP_N];
  logic [INDEX_WIDTH-1:0]  root_n [TOP_N];
  logic [FILL_WIDTH-1:0]   fill_cnt;
  logic [SIZE_WIDTH-1:0]   cur_size;
  logic [WIDE_WIDTH-1:0]   mul_wide;

  // Slots stay sorted with empties last, so "better" is monotonic across slots:
  // a slot takes the newcomer where better first rises, and shifts where the slot above was better.
  always_comb begin
    qualify     = r_valid && r_is_root && (r_size != '0);
    better_ext  = '0;
    size_ext[0] = r_size;
    root_ext[0] = r_cnt[INDEX_WIDTH-1:0];
    for (int unsigned d = 0; d < TOP_N; d++) begin
      size_ext[d+1] = size_q[d];
      root_ext[d+1] = root_q[d];
      if (MODE == 0)
        better_ext[d+1] = (size_q[d] == '0) || (r_size > size_q[d]);
      else
        better_ext[d+1] = (size_q[d] == '0) || (r_size < size_q[d]);
    end
    for (int unsigned d = 0; d < TOP_N; d++) begin
      if (better_ext[d]) begin
        size_n[d] = size_ext[d];
        root_n[d] = root_ext[d];
      end else if (better_ext[d+1]) begin
        size_n[d] = r_size;
        root_n[d] = root_ext[0];
      end else begin
        size_n[d] = size_q[d];
        root_n[d] = root_q[d];
      end
    end
  end

  // Filled-slot count and the operand for the current product step.
  always_comb begin
    fill_cnt = '0;
    cur_size = '0;
    for (int unsigned d = 0; d < TOP_N; d++) begin
      if (size_q[d] != '0) fill_cnt = fill_cnt + FILL_WIDTH'(1);
      if (prod_idx == FILL_WIDTH'(d)) cur_size = size_q[d];
    end
    mul_wide = WIDE_WIDTH'(acc) * WIDE_WIDTH'(cur_size);
  end

  always_comb begin
    top_sizes = '0;
    top_roots = '0;
    for (int unsigned d = 0; d < TOP_N; d++) begin
      top_sizes[d*SIZE_WIDTH +: SIZE_WIDTH]   = size_q[d];
      top_roots[d*INDEX_WIDTH +: INDEX_WIDTH] = root_q[d];
    end
  end

  assign q_index = q_cnt[INDEX_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      q_valid     <= 1'b0;
      out_valid   <= 1'b0;
      q_cnt       <= '0;
      r_cnt       <= '0;
      roots_found <= '0;
      top_product <= '0;
      overflow    <= 1'b0;
      acc         <= '0;
      prod_idx    <= '0;
      for (int unsigned d = 0; d < TOP_N; d++) begin
        size_q[d] <= '0;
        root_q[d] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SWEEP;
            busy        <= 1'b1;
            q_valid     <= 1'b1;
            q_cnt       <= '0;
            r_cnt       <= '0;
            roots_found <= '0;
            overflow    <= 1'b0;
            for (int unsigned d = 0; d < TOP_N; d++) begin
              size_q[d] <= '0;
              root_q[d] <= '0;
            end
          end
        end
        SWEEP: begin
          if (q_valid && q_ready) begin
            q_cnt <= q_cnt + CNT_WIDTH'(1);
            if (q_cnt == LAST_CNT) q_valid <= 1'b0;
          end
          if (r_valid) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (qualify) begin
              size_q <= size_n;
              root_q <= root_n;
              if (roots_found != NODE_MAX) roots_found <= roots_found + CNT_WIDTH'(1);
            end
            if (r_cnt == LAST_CNT) begin
              state    <= PRODUCT;
              acc      <= PRODUCT_WIDTH'(1);
              prod_idx <= '0;
            end
          end
        end
        PRODUCT: begin
          if (fill_cnt == '0) begin
            top_product <= '0;
            state       <= HOLD;
            busy        <= 1'b0;
            out_valid   <= 1'b1;
          end else begin
            acc <= mul_wide[PRODUCT_WIDTH-1:0];
            if (|mul_wide[WIDE_WIDTH-1:PRODUCT_WIDTH]) overflow <= 1'b1;
            if (prod_idx == fill_cnt - FILL_WIDTH'(1)) begin
              top_product <= mul_wide[PRODUCT_WIDTH-1:0];
              state       <= HOLD;
              busy        <= 1'b0;
              out_valid   <= 1'b1;
            end else begin
              prod_idx <= prod_idx + FILL_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_component_rank_sweep.sv
// Directed bench for component_rank_sweep: one MODE 0 and one MODE 1 instance
// share stimulus; a selection-sort model supplies the expected ranking.
module tb_component_rank_sweep;

  localparam int NC = 8;
  localparam int IW = 3;
  localparam int SW = 5;
  localparam int TN = 3;
  localparam int PW = 8;

  logic clk, rst_n, start, q_ready, r_valid, r_is_root, out_ready;
  logic [SW-1:0] r_size;

  logic busy0, q_valid0, out_valid0, overflow0;
  logic [IW-1:0] q_index0;
  logic [TN*SW-1:0] top_sizes0;
  logic [TN*IW-1:0] top_roots0;
  logic [IW:0] roots_found0;
  logic [PW-1:0] top_product0;

  logic busy1, q_valid1, out_valid1, overflow1;
  logic [IW-1:0] q_index1;
  logic [TN*SW-1:0] top_sizes1;
  logic [TN*IW-1:0] top_roots1;
  logic [IW:0] roots_found1;
  logic [PW-1:0] top_product1;

  component_rank_sweep #(.NODE_COUNT(NC), .INDEX_WIDTH(IW), .SIZE_WIDTH(SW), .TOP_N(TN),
                         .MODE(0), .PRODUCT_WIDTH(PW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .q_valid(q_valid0),
    .q_ready(q_ready), .q_index(q_index0), .r_valid(r_valid), .r_is_root(r_is_root),
    .r_size(r_size), .out_valid(out_valid0), .out_ready(out_ready),
    .top_sizes(top_sizes0), .top_roots(top_roots0), .roots_found(roots_found0),
    .top_product(top_product0), .overflow(overflow0));

  component_rank_sweep #(.NODE_COUNT(NC), .INDEX_WIDTH(IW), .SIZE_WIDTH(SW), .TOP_N(TN),
                         .MODE(1), .PRODUCT_WIDTH(PW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .q_valid(q_valid1),
    .q_ready(q_ready), .q_index(q_index1), .r_valid(r_valid), .r_is_root(r_is_root),
    .r_size(r_size), .out_valid(out_valid1), .out_ready(out_ready),
    .top_sizes(top_sizes1), .top_roots(top_roots1), .roots_found(roots_found1),
    .top_product(top_product1), .overflow(overflow1));

  int checks = 0;
  int errors = 0;

  logic          tbl_root [NC];
  logic [SW-1:0] tbl_size [NC];
  logic [SW-1:0] e_size [2][TN];
  logic [IW-1:0] e_root [2][TN];
  int            e_found [2];
  logic [PW-1:0] e_prod [2];
  logic          e_ovf [2];
  bit            stall = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [TN*SW-1:0] pk_s(input int a, input int b, input int c);
    return {SW'(c), SW'(b), SW'(a)};
  endfunction

  function automatic logic [TN*IW-1:0] pk_r(input int a, input int b, input int c);
    return {IW'(c), IW'(b), IW'(a)};
  endfunction

  // Expected ranking by repeated selection of the strictly best remaining root.
  task automatic model(input int m);
    int idx[$];
    int sz[$];
    bit used[NC];
    longint p;
    int filled;
    int best;
    e_found[m] = 0;
    for (int i = 0; i < NC; i++) begin
      used[i] = 1'b0;
      if (tbl_root[i] && tbl_size[i] != 0) begin
        idx.push_back(i);
        sz.push_back(int'(tbl_size[i]));
        e_found[m]++;
      end
    end
    if (e_found[m] > NC) e_found[m] = NC;
    p = 1;
    filled = 0;
    for (int k = 0; k < TN; k++) begin
      best = -1;
      for (int j = 0; j < idx.size(); j++)
        if (!used[j] && (best < 0 || (m == 0 ? sz[j] > sz[best] : sz[j] < sz[best])))
          best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        e_size[m][k] = SW'(sz[best]);
        e_root[m][k] = IW'(idx[best]);
        p = p * sz[best];
        filled++;
      end else begin
        e_size[m][k] = '0;
        e_root[m][k] = '0;
      end
    end
    if (filled == 0) p = 0;
    e_prod[m] = PW'(p);
    e_ovf[m]  = (p > 255);
  endtask

  task automatic clear_table();
    for (int i = 0; i < NC; i++) begin
      tbl_root[i] = 1'b0;
      tbl_size[i] = SW'($urandom_range(1, 31));
    end
  endtask

  task automatic set_root(input int i, input int s);
    tbl_root[i] = 1'b1;
    tbl_size[i] = SW'(s);
  endtask

  // Response source: answers each accepted query two cycles later, in order.
  initial begin : responder
    bit p1v, p2v;
    int p1i, p2i;
    p1v = 0; p2v = 0; p1i = 0; p2i = 0;
    q_ready = 1'b1; r_valid = 1'b0; r_is_root = 1'b0; r_size = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p1v = 0; p2v = 0;
        r_valid = 1'b0;
      end else begin
        r_valid   = p2v;
        r_is_root = tbl_root[p2i];
        r_size    = tbl_size[p2i];
        p2v = p1v; p2i = p1i;
        q_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        p1v = q_valid0 && q_ready;
        p1i = int'(q_index0);
      end
    end
  end

  // Whenever results are presented they must match the model, every cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      chk("d0_sizes", top_sizes0, {e_size[0][2], e_size[0][1], e_size[0][0]});
      chk("d0_roots", top_roots0, {e_root[0][2], e_root[0][1], e_root[0][0]});
      chk("d0_found", roots_found0, e_found[0]);
      chk("d0_product", top_product0, e_prod[0]);
      chk("d0_overflow", overflow0, e_ovf[0]);
      chk("d0_busy_hold", busy0, 0);
    end
    if (rst_n && out_valid1) begin
      chk("d1_sizes", top_sizes1, {e_size[1][2], e_size[1][1], e_size[1][0]});
      chk("d1_roots", top_roots1, {e_root[1][2], e_root[1][1], e_root[1][0]});
      chk("d1_found", roots_found1, e_found[1]);
      chk("d1_product", top_product1, e_prod[1]);
      chk("d1_overflow", overflow1, e_ovf[1]);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_q_valid"}, q_valid0, 0);
    chk({tag, "_out_valid"}, out_valid0, 0);
    chk({tag, "_sizes"}, top_sizes0, 0);
    chk({tag, "_roots"}, top_roots0, 0);
    chk({tag, "_found"}, roots_found0, 0);
    chk({tag, "_product"}, top_product0, 0);
    chk({tag, "_overflow"}, overflow0, 0);
    chk({tag, "_d1_product"}, top_product1, 0);
    chk({tag, "_d1_sizes"}, top_sizes1, 0);
  endtask

  task automatic run_sweep(input bit stall_en, input bit pulse);
    int n;
    model(0);
    model(1);
    stall = stall_en;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy0, 1);
    chk("q_valid_after_start", q_valid0, 1);
    n = 0;
    while (!out_valid0 && n < 300) begin
      @(negedge clk);
      start = pulse && busy0 && ($urandom_range(0, 3) == 0);
      n++;
    end
    start = 1'b0;
    stall = 1'b0;
    chk("sweep_done", out_valid0, 1);
  endtask

  task automatic finish_hold(input int hold_cycles, input bit pulse);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      start = pulse && ($urandom_range(0, 1) == 1);
    end
    @(negedge clk); out_ready = 1'b1; start = pulse;
    @(negedge clk); out_ready = 1'b0; start = 1'b0;
    chk("out_valid_dropped", out_valid0, 0);
    repeat (3) @(negedge clk);
    chk("no_restart_busy", busy0, 0);
    chk("no_restart_q_valid", q_valid0, 0);
    chk("result_retained", top_product0, e_prod[0]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    clear_table();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Basic ranking, with a zero-size root that must not qualify.
    clear_table();
    set_root(0, 5); set_root(3, 2); set_root(5, 1);
    tbl_root[6] = 1'b1; tbl_size[6] = '0;
    run_sweep(0, 0);
    chk("a_d0_sizes", top_sizes0, pk_s(5, 2, 1));
    chk("a_d0_roots", top_roots0, pk_r(0, 3, 5));
    chk("a_d0_found", roots_found0, 3);
    chk("a_d0_product", top_product0, 10);
    chk("a_d0_overflow", overflow0, 0);
    chk("a_d1_sizes", top_sizes1, pk_s(1, 2, 5));
    chk("a_d1_roots", top_roots1, pk_r(5, 3, 0));
    finish_hold(0, 0);

    // Equal sizes: earliest indices keep the slots.
    clear_table();
    set_root(1, 4); set_root(4, 4); set_root(6, 4); set_root(7, 4);
    run_sweep(0, 0);
    chk("tie_d0_roots", top_roots0, pk_r(1, 4, 6));
    chk("tie_d0_product", top_product0, 64);
    chk("tie_d0_found", roots_found0, 4);
    chk("tie_d1_roots", top_roots1, pk_r(1, 4, 6));
    finish_hold(0, 0);

    // Single root leaves empty slots reading zero.
    clear_table();
    set_root(2, 8);
    run_sweep(0, 0);
    chk("one_d0_sizes", top_sizes0, pk_s(8, 0, 0));
    chk("one_d0_roots", top_roots0, pk_r(2, 0, 0));
    chk("one_d0_product", top_product0, 8);
    finish_hold(0, 0);

    // 20*20*20 = 8000 wraps to 64 in 8 bits.
    clear_table();
    set_root(0, 20); set_root(1, 20); set_root(2, 20);
    run_sweep(0, 0);
    chk("ovf_d0_product", top_product0, 64);
    chk("ovf_d0_overflow", overflow0, 1);
    chk("ovf_d1_overflow", overflow1, 1);
    finish_hold(0, 0);

    // Reset part way through a sweep, then an unrelated sweep.
    clear_table();
    set_root(0, 5); set_root(3, 2); set_root(5, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_table();
    set_root(2, 3); set_root(6, 7);
    run_sweep(0, 0);
    chk("post_d0_sizes", top_sizes0, pk_s(7, 3, 0));
    chk("post_d0_roots", top_roots0, pk_r(6, 2, 0));
    chk("post_d0_product", top_product0, 21);
    chk("post_d1_sizes", top_sizes1, pk_s(3, 7, 0));
    finish_hold(0, 0);

    // No qualifying roots: product reads 0.
    clear_table();
    run_sweep(0, 0);
    chk("empty_product", top_product0, 0);
    chk("empty_sizes", top_sizes0, 0);
    chk("empty_found", roots_found0, 0);
    finish_hold(0, 0);

    // Stalled queries, start pulses while busy, long hold with start alongside out_ready.
    clear_table();
    set_root(0, 5); set_root(3, 2); set_root(5, 1);
    run_sweep(1, 1);
    chk("stall_d0_sizes", top_sizes0, pk_s(5, 2, 1));
    chk("stall_d0_product", top_product0, 10);
    finish_hold(10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
